// File: rtl/encrypt_cbc_pkg.sv
// Shared widths, FSM encoding and cipher round constants for the CBC encryptor.
package encrypt_cbc_pkg;

   localparam int unsigned N_K      = 64;
   localparam int unsigned N_B      = 32;
   localparam int unsigned N_CNT    = 16;
   localparam int unsigned N_ROUNDS = 4;
   localparam int unsigned RW       = $clog2(N_ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XOR  = 2'd1,
      S_ENC  = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   // Multiples of the golden-ratio constant, one per round.
   localparam logic [N_B-1:0] ROUND_C [N_ROUNDS] = '{
      32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B, 32'h78DDE6E4
   };

endpackage

// File: rtl/encrypt_cbc_comb.sv
// Combinational block cipher E(k, m): key-alternating xor, rotate-left-5, add round constant.
module encrypt_comb
   import encrypt_cbc_pkg::*;
(
   input  logic [N_K-1:0] k,
   input  logic [N_B-1:0] m,
   output logic [N_B-1:0] c
);

   logic [N_B-1:0] kw [2];
   logic [N_B-1:0] s;

   assign kw[0] = k[N_B-1:0];
   assign kw[1] = k[N_K-1:N_B];

   always_comb begin
      s = m;
      for (int unsigned r = 0; r < N_ROUNDS; r++) begin
         s = s ^ kw[r[0]];
         s = {s[N_B-6:0], s[N_B-1:N_B-5]};
         s = s + ROUND_C[r[RW-1:0]];
      end
      c = s;
   end

endmodule

// File: rtl/encrypt_cbc.sv
// CBC-mode encryptor with a 4-phase req/ack handshake around a single combinational cipher.
module encrypt_cbc
   import encrypt_cbc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [N_K-1:0]   k,
   input  logic [N_B-1:0]   iv,
   input  logic             req,
   input  logic [N_B-1:0]   m,
   output logic             ack,
   output logic [N_B-1:0]   c,
   output logic [N_CNT-1:0] cnt
);

   state_t             state_q, state_d;
   logic [N_K-1:0]     k_q, k_d;
   logic [N_B-1:0]     chain_q, chain_d;
   logic [N_B-1:0]     x_q, x_d;
   logic [N_B-1:0]     c_q, c_d;
   logic [N_CNT-1:0]   cnt_q, cnt_d;
   logic [N_B-1:0]     enc_c;

   encrypt_comb u_enc (
      .k (k_q),
      .m (x_q),
      .c (enc_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = S_XOR;
         S_XOR:   state_d = S_ENC;
         S_ENC:   state_d = S_ACK;
         S_ACK:   if (!req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Init and req in the same cycle: the block is chained off the new IV, not the old chain.
   always_comb begin
      k_d     = k_q;
      chain_d = chain_q;
      x_d     = x_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      ack     = (state_q == S_ACK);
      case (state_q)
         S_IDLE: begin
            if (init) begin
               k_d     = k;
               chain_d = iv;
               cnt_d   = '0;
            end
            if (req) x_d = m ^ (init ? iv : chain_q);
         end
         S_ENC: begin
            c_d     = enc_c;
            chain_d = enc_c;
            cnt_d   = cnt_q + N_CNT'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q     <= '0;
         chain_q <= '0;
         x_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
      end else begin
         k_q     <= k_d;
         chain_q <= chain_d;
         x_q     <= x_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   assign c   = c_q;
   assign cnt = cnt_q;

endmodule
